// File: rtl/pr_request_queue_mc_pkg.sv
// pr_request_queue_mc_pkg: shared entry type, register map and head-word packing for the PR request queue.
package pr_request_queue_mc_pkg;
    typedef struct packed {
        logic [7:0]  channel;
        logic [15:0] cfg_id;
    } pr_queue_entry_t;
    localparam logic [3:0] PRQ_STATUS_ADDR   = 4'h0;
    localparam logic [3:0] PRQ_HEAD_ADDR     = 4'h4;
    localparam logic [3:0] PRQ_INFLIGHT_ADDR = 4'h8;
    localparam logic [3:0] PRQ_COMPLETE_ADDR = 4'h0;
    localparam logic [3:0] PRQ_FLUSH_ADDR    = 4'h4;
    function automatic logic [31:0] prq_head_word(input pr_queue_entry_t e);
        return {1'b1, 7'b0, e.channel, e.cfg_id};
    endfunction
endpackage

// File: rtl/pr_queue_axil_slave.sv
// pr_queue_axil_slave: AXI-lite handshakes; turns accepted reads/writes into single-cycle strobes and registers the response.
module pr_queue_axil_slave (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [3:0]  s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        rd_strobe,
    output logic [3:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        wr_strobe,
    output logic [3:0]  wr_addr,
    output logic [31:0] wr_data
);
    assign s_axi_arready = !s_axi_rvalid;
    assign rd_strobe     = s_axi_arvalid & !s_axi_rvalid;
    assign rd_addr       = s_axi_araddr;
    // address and data are only taken together so a write is always one strobe
    assign wr_strobe     = s_axi_awvalid & s_axi_wvalid & !s_axi_bvalid;
    assign s_axi_awready = wr_strobe;
    assign s_axi_wready  = wr_strobe;
    assign wr_addr       = s_axi_awaddr;
    assign wr_data       = s_axi_wdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_bvalid <= 1'b0;
        end else begin
            if (rd_strobe) begin
                s_axi_rdata  <= rd_data;
                s_axi_rvalid <= 1'b1;
            end else if (s_axi_rready) s_axi_rvalid <= 1'b0;
            if (wr_strobe) s_axi_bvalid <= 1'b1;
            else if (s_axi_bready) s_axi_bvalid <= 1'b0;
        end
    end
endmodule

// File: rtl/pr_request_queue_mc.sv
// pr_request_queue_mc: multi-channel PR request FIFO with per-channel busy tracking and coalescing,
// drained by a host over AXI-lite.
module pr_request_queue_mc
    import pr_request_queue_mc_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int CFG_ID_W     = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [$clog2(NUM_CHANNELS)-1:0] req_channel,
    input  logic [CFG_ID_W-1:0]             req_cfg_id,
    output logic [NUM_CHANNELS-1:0]         chan_busy,
    output logic [$clog2(DEPTH):0]          queue_count,
    output logic                            pr_request_pending,
    input  logic [3:0]                      s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [31:0]                     s_axi_wdata,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [3:0]                      s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [31:0]                     s_axi_rdata,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready
);
    localparam int CW = $clog2(NUM_CHANNELS);
    localparam int PW = $clog2(DEPTH);
    pr_queue_entry_t entries [DEPTH];
    pr_queue_entry_t head_ent;
    logic [PW-1:0] head, tail, wr_base;
    logic [PW-1:0] slot [NUM_CHANNELS];
    logic [PW:0] count;
    logic [NUM_CHANNELS-1:0] queued, inflight;
    logic [CW-1:0] pop_ch, cpl_ch;
    logic rd_strobe, wr_strobe, push, pop, fresh, coalesce, complete, flush, unused_bits;
    logic [3:0] rd_addr, wr_addr;
    logic [31:0] rd_data, wr_data;
    pr_queue_axil_slave u_axil (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .rd_strobe(rd_strobe), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
    );
    assign head_ent           = entries[head];
    assign pop_ch             = head_ent.channel[CW-1:0];
    assign cpl_ch             = wr_data[CW-1:0];
    assign unused_bits        = ^wr_data[31:8];
    assign req_ready          = queued[req_channel] | (count < (PW+1)'(DEPTH));
    assign push               = req_valid & req_ready;
    assign pop                = rd_strobe && rd_addr == PRQ_HEAD_ADDR && count != '0;
    assign complete           = wr_strobe && wr_addr == PRQ_COMPLETE_ADDR && 32'(wr_data[7:0]) < NUM_CHANNELS;
    assign flush              = wr_strobe && wr_addr == PRQ_FLUSH_ADDR && wr_data[0];
    // a repeat to the channel leaving the queue this cycle must become a new entry, not a lost overwrite
    assign coalesce           = push && queued[req_channel] && !flush && !(pop && pop_ch == req_channel);
    assign fresh              = push & !coalesce;
    assign wr_base            = flush ? '0 : tail;
    assign chan_busy          = queued | inflight;
    assign queue_count        = count;
    assign pr_request_pending = count != '0;
    assign rd_data = rd_addr == PRQ_STATUS_ADDR   ? {8'(NUM_CHANNELS), 6'b0, count == (PW+1)'(DEPTH), count == '0, 16'(count)}
                   : rd_addr == PRQ_HEAD_ADDR     ? (count != '0 ? prq_head_word(head_ent) : '0)
                   : rd_addr == PRQ_INFLIGHT_ADDR ? 32'(inflight)
                   : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            queued   <= '0;
            inflight <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) slot[i] <= '0;
        end else begin
            head  <= flush ? '0 : head + PW'(pop);
            tail  <= wr_base + PW'(fresh);
            count <= (flush ? '0 : count - (PW+1)'(pop)) + (PW+1)'(fresh);
            if (flush) queued <= '0;
            if (pop) queued[pop_ch] <= 1'b0;
            if (fresh) begin
                queued[req_channel] <= 1'b1;
                slot[req_channel]   <= wr_base;
            end
            // pop is applied after complete so a same-channel pair leaves the channel in flight
            if (complete) inflight[cpl_ch] <= 1'b0;
            if (pop) inflight[pop_ch] <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (fresh) entries[wr_base] <= '{channel: 8'(req_channel), cfg_id: 16'(req_cfg_id)};
        if (coalesce) entries[slot[req_channel]].cfg_id <= 16'(req_cfg_id);
    end
endmodule

// File: tb/tb_pr_request_queue_mc.sv
// tb_pr_request_queue_mc: directed checks of queueing, coalescing, pop/complete/flush and AXI-lite stalls.
module tb_pr_request_queue_mc;
    logic clk = 0, rst = 1;
    logic req_valid = 0, req_ready;
    logic [3:0] req_channel = 0;
    logic [7:0] req_cfg_id = 0;
    logic [15:0] chan_busy;
    logic [3:0] queue_count;
    logic pr_request_pending;
    logic [3:0] awaddr = 0, araddr = 0;
    logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 1;
    logic [31:0] wdata = 0, rdata, d;
    logic arvalid = 0, arready, rvalid, rready = 1;
    int errors = 0, checks = 0;

    pr_request_queue_mc #(.DEPTH(8), .NUM_CHANNELS(16), .CFG_ID_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_channel(req_channel), .req_cfg_id(req_cfg_id), .chan_busy(chan_busy),
        .queue_count(queue_count), .pr_request_pending(pr_request_pending),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] ch, input logic [7:0] cfg);
        @(negedge clk);
        req_valid = 1; req_channel = ch; req_cfg_id = cfg;
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] v);
        int n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1; rready = 1;
        @(negedge clk);
        arvalid = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        chk("rvalid_seen", 32'(rvalid), 32'd1);
        v = rdata;
        @(negedge clk);
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] v);
        int n = 0;
        @(negedge clk);
        awaddr = a; wdata = v; awvalid = 1; wvalid = 1; bready = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        chk("bvalid_seen", 32'(bvalid), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_count", 32'(queue_count), 0);
        chk("rst_pending", 32'(pr_request_pending), 0);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_busy", 32'(chan_busy), 0);
        chk("rst_rvalid_bvalid", {rvalid, bvalid}, 0);
        chk("rst_rdata", rdata, 0);

        push(1, 8'h05);
        chk("p1_count", 32'(queue_count), 1);
        chk("p1_busy", 32'(chan_busy), 32'h2);
        chk("p1_pending", 32'(pr_request_pending), 1);
        axi_read(4'h4, d);
        chk("p1_head", d, 32'h8001_0005);
        chk("p1_count_after", 32'(queue_count), 0);
        axi_read(4'h8, d);
        chk("p1_inflight", d, 32'h2);
        axi_write(4'h0, 32'd1);

        push(2, 8'h10);
        push(2, 8'h11);
        chk("coal_count", 32'(queue_count), 1);
        axi_read(4'h4, d);
        chk("coal_head", d, 32'h8002_0011);
        axi_write(4'h0, 32'd2);
        axi_read(4'h8, d);
        chk("cpl_inflight_clear", d, 0);

        for (int i = 0; i < 8; i++) push(4'(i), 8'(8'h40 + i));
        chk("full_count", 32'(queue_count), 8);
        req_channel = 9;
        #1 chk("full_new_ready", 32'(req_ready), 0);
        req_channel = 3;
        #1 chk("full_queued_ready", 32'(req_ready), 1);
        axi_read(4'h0, d);
        chk("full_status", d, 32'h1002_0008);
        @(negedge clk);
        araddr = 4'h4; arvalid = 1; rready = 1;
        req_valid = 1; req_channel = 0; req_cfg_id = 8'h99;
        @(negedge clk);
        arvalid = 0; req_valid = 0;
        chk("pp_head", rdata, 32'h8000_0040);
        chk("pp_count", 32'(queue_count), 8);
        push(5, 8'h55);
        chk("full_coal_count", 32'(queue_count), 8);
        axi_write(4'h4, 32'd1);
        chk("flush_count", 32'(queue_count), 0);
        axi_read(4'h8, d);
        chk("flush_keeps_inflight", d, 32'h1);
        axi_read(4'h4, d);
        chk("empty_head", d, 0);
        chk("empty_head_count", 32'(queue_count), 0);
        axi_write(4'h0, 32'd0);

        push(3, 8'h30);
        axi_read(4'h4, d);
        chk("ch3_pop", d, 32'h8003_0030);
        push(3, 8'h22);
        chk("ch3_inflight_push_count", 32'(queue_count), 1);
        axi_write(4'h0, 32'd3);
        axi_read(4'h8, d);
        chk("ch3_cpl_inflight", d, 0);
        chk("ch3_busy", 32'(chan_busy), 32'h8);
        axi_read(4'h4, d);
        chk("ch3_head2", d, 32'h8003_0022);
        axi_write(4'h0, 32'h13);
        axi_read(4'h8, d);
        chk("cpl_out_of_range", d, 32'h8);
        axi_write(4'h0, 32'd3);

        push(4, 8'h01);
        push(5, 8'h02);
        push(6, 8'h03);
        chk("three_count", 32'(queue_count), 3);
        @(negedge clk);
        awaddr = 4'h4; wdata = 1; awvalid = 1; wvalid = 1;
        req_valid = 1; req_channel = 0; req_cfg_id = 8'h07;
        @(negedge clk);
        awvalid = 0; wvalid = 0; req_valid = 0;
        chk("flush_push_count", 32'(queue_count), 1);
        chk("flush_push_busy", 32'(chan_busy), 32'h1);
        axi_read(4'h4, d);
        chk("flush_push_head", d, 32'h8000_0007);
        axi_write(4'h0, 32'd0);

        push(9, 8'h9A);
        @(negedge clk);
        araddr = 4'h0; arvalid = 1; rready = 0;
        @(negedge clk);
        araddr = 4'h4;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rvalid", 32'(rvalid), 1);
            chk("stall_rdata", rdata, 32'h1000_0001);
            chk("stall_arready", 32'(arready), 0);
            @(negedge clk);
        end
        arvalid = 0;
        chk("stall_no_pop", 32'(queue_count), 1);
        rready = 1;
        @(negedge clk);
        chk("stall_release", 32'(rvalid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
